k2_unscale: RTL and testbench
=============================

// Module: k2_unscale
// PURPOSE
//  Streaming inverse of the K2RED domain: takes 12-bit signed K2RED results (congruent to 169*a mod q)
//  and returns canonical a mod q in [0,q), q=3329, by multiplying with k^-2 = 169^-1 = 2285 mod q.
//  Sits at the output of the NTT/pointwise datapath, before pack/compress; valid/ready on both sides.
//  3-stage pipeline, full throughput (1 coeff/clk), stalls cleanly under backpressure.
// PARAMETERS
//  WID2       12     coefficient width (in and out)
//  Q          3329   Kyber modulus
//  K2INV      2285   169^-1 mod Q (169*2285 = 116*Q + 1)
//  BRT_M      5039   Barrett constant floor(2^24/Q)
//  BRT_SH     24     Barrett shift
//  NCOEF      256    coefficients per polynomial (out_last period)
// PORTS
//  clk        in   1     clock, all logic on rising edge
//  rst        in   1     reset, asynchronous assert, active-low
//  in_valid   in   1     input coefficient valid
//  in_ready   out  1     block accepts input this cycle
//  in_data    in   12    two's-complement K2RED result, -2048..2047
//  out_valid  out  1     output coefficient valid
//  out_ready  in   1     downstream accepts output
//  out_data   out  12    canonical coefficient, 0..Q-1
//  out_last   out  1     high with the NCOEF-th output of each polynomial
// BEHAVIOUR
//  - Reset (rst=0, async): all stage valids 0, out_valid=0, out_data=0, out_last=0, coeff counter=0.
//    Reset mid-stream drops all in-flight coefficients; no partial output after release.
//  - Advance: adv = ~out_valid | out_ready; every stage register loads only when adv=1.
//    in_ready = adv (combinational, no skid). Transfer = valid & ready on each side.
//  - ST1 (reg p): u = in_data<0 ? in_data+Q : in_data (u in 0..3328); p = u*K2INV, 23 bits unsigned.
//  - ST2 (reg r): t = (p*BRT_M)>>BRT_SH; r = p - t*Q, 13 bits; guaranteed 0 <= r < 2Q.
//  - ST3 (reg out): out_data = r>=Q ? r-Q : r; out_data never >= Q.
//  - Latency 3 clk from input transfer to out_valid when unstalled; stage valids shift with data,
//    bubbles propagate (no bubble collapsing). While out_valid & ~out_ready, out_data/out_last held stable.
//  - Coeff counter (log2(NCOEF) bits) increments on each output transfer; out_last = (cnt==NCOEF-1)
//    aligned with ST3 data; wraps to 0 after the last transfer. Simultaneous in/out transfer legal every clk.
//  - All arithmetic unsigned after ST1 fold; no X on out_data when out_valid=0 (holds last value).
// CONFIGURATION
//  K2U_SKID_EN defined: 2-entry input skid buffer; in_ready driven from a flop
//    (in_ready = skid not full), breaking the out_ready->in_ready comb path; latency +1 (4 clk),
//    throughput unchanged; skid cleared by reset.
//  K2U_SKID_EN undefined: in_ready = adv combinationally, latency 3, no skid storage.
// STRUCTURE
//  - k2_pkg: Q, K2INV, BRT_M, BRT_SH, NCOEF, WID2 localparams; coeff_t (12-bit) typedef shared
//    with k2red and pack/compress blocks.
//  - Sub-module k2_barrett: combinational p(23b) -> r(13b, < 2Q) reduction used by ST2; reusable
//    by other modular multipliers in the datapath.
// TESTING
//  1 in_data=169 -> out_data=1 after 3 clk (4 with K2U_SKID_EN); in_data=0 -> 0.
//  2 in_data=-1 (0xFFF) -> 1044; in_data=-169 (0xF57) -> 3328; in_data=2047 -> 150.
//  3 256 back-to-back inputs, out_ready=1 -> 256 outputs on consecutive clk, out_last only on 256th.
//  4 random out_ready toggling (50%) over 1000 random inputs -> in-order, no loss/dup, data stable while stalled,
//    every result equals (in*2285) mod 3329 from a reference model.
//  5 rst=0 asserted with 3 coeffs in flight -> out_valid=0 same cycle, counter=0; first post-reset output
//    is the first post-reset input, out_last on its 256th output.
//  6 exhaustive sweep of all 4096 in_data values -> out_data < 3329 and 169*out_data == in_data mod 3329.

Source files
------------

// File: rtl/k2_unscale_pkg.sv
// Shared constants and types for the K2RED un-scaling datapath.
// Coefficient type coeff_t is shared with the k2red and pack/compress blocks.
package k2_unscale_pkg;

  localparam int WID2   = 12;
  localparam int Q      = 3329;
  localparam int K2INV  = 2285;
  localparam int BRT_M  = 5039;
  localparam int BRT_SH = 24;
  localparam int NCOEF  = 256;

  localparam int PW     = 23;
  localparam int RW     = 13;
  localparam int CNT_W  = $clog2(NCOEF);

  typedef logic [WID2-1:0] coeff_t;
  typedef logic [PW-1:0]   prod_t;
  typedef logic [RW-1:0]   red_t;

  // Map a two's-complement coefficient into 0..Q-1 (input is within +-Q).
  function automatic coeff_t fold_signed(input coeff_t x);
    if (x[WID2-1]) begin
      return x + coeff_t'(Q);
    end else begin
      return x;
    end
  endfunction

  // Final conditional subtraction: 0..2Q-1 -> 0..Q-1.
  function automatic coeff_t fold_q(input red_t r);
    if (r >= red_t'(Q)) begin
      return coeff_t'(r - red_t'(Q));
    end else begin
      return coeff_t'(r);
    end
  endfunction

endpackage

// File: rtl/k2_unscale_barrett.sv
// Combinational Barrett reduction: 23-bit product -> 13-bit residue in [0, 2Q).
// Reusable by other modular multipliers in the datapath.
import k2_unscale_pkg::*;

module k2_barrett (
  input  prod_t p,
  output red_t  r
);

  logic [35:0] wide;
  logic [11:0] t;

  // Quotient estimate t = floor(p*M / 2^SH), then residue r = p - t*Q.
  always_comb begin
    wide = 36'(p) * 36'(BRT_M);
    t    = 12'(wide >> BRT_SH);
    r    = RW'(p - PW'(t) * PW'(Q));
  end

endmodule

// File: rtl/k2_unscale.sv
// k2_unscale: streaming inverse of the K2RED domain, out = in * 169^-1 mod Q.
// Three register stages (fold+multiply, Barrett, final subtract), 1 coeff/clk.
// Optional macro K2U_SKID_EN adds a 2-entry input skid buffer with a
// registered in_ready (latency becomes 4 clk).
import k2_unscale_pkg::*;

module k2_unscale (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WID2-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WID2-1:0] out_data,
  output logic            out_last
);

  logic             adv;
  logic             out_xfer;
  logic             src_valid;
  coeff_t           src_data;
  logic             v1;
  logic             v2;
  prod_t            p;
  red_t             r;
  red_t             r_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_after;

  assign adv      = ~out_valid | out_ready;
  assign out_xfer = out_valid & out_ready;

`ifdef K2U_SKID_EN
  coeff_t     s0;
  coeff_t     s1;
  logic [1:0] sc;
  logic [1:0] sc_next;
  logic       push;
  logic       pop;

  assign push      = in_valid & in_ready;
  assign pop       = adv & (sc != 2'd0);
  assign src_valid = (sc != 2'd0);
  assign src_data  = s0;

  // Skid occupancy after this cycle's push/pop.
  always_comb begin
    sc_next = sc;
    if (push && !pop) begin
      sc_next = sc + 2'd1;
    end else if (pop && !push) begin
      sc_next = sc - 2'd1;
    end else begin
      sc_next = sc;
    end
  end

  // Skid storage (s0 is the head) and registered in_ready = not full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc       <= 2'd0;
      s0       <= '0;
      s1       <= '0;
      in_ready <= 1'b1;
    end else begin
      sc       <= sc_next;
      in_ready <= (sc_next != 2'd2);
      if (pop) begin
        if (push && (sc == 2'd1)) begin
          s0 <= in_data;
        end else begin
          s0 <= s1;
        end
      end else if (push) begin
        if (sc == 2'd0) begin
          s0 <= in_data;
        end else begin
          s1 <= in_data;
        end
      end
    end
  end
`else
  assign in_ready  = adv;
  assign src_valid = in_valid;
  assign src_data  = in_data;
`endif

  k2_barrett u_barrett (
    .p (p),
    .r (r_next)
  );

  // Output counter helpers: next value with wrap, and value after this cycle.
  always_comb begin
    if (cnt == CNT_W'(NCOEF - 1)) begin
      cnt_inc = '0;
    end else begin
      cnt_inc = cnt + CNT_W'(1);
    end
    if (out_xfer) begin
      cnt_after = cnt_inc;
    end else begin
      cnt_after = cnt;
    end
  end

  // Pipeline stages and output counter; everything advances together on adv.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      p         <= '0;
      r         <= '0;
      cnt       <= '0;
    end else begin
      if (out_xfer) begin
        cnt <= cnt_inc;
      end
      if (adv) begin
        v1        <= src_valid;
        v2        <= v1;
        out_valid <= v2;
        if (src_valid) begin
          p <= prod_t'(fold_signed(src_data)) * prod_t'(K2INV);
        end
        if (v1) begin
          r <= r_next;
        end
        if (v2) begin
          out_data <= fold_q(r);
          out_last <= (cnt_after == CNT_W'(NCOEF - 1));
        end else begin
          out_last <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_k2_unscale.sv
// Self-checking bench for k2_unscale: directed vectors, back-to-back stream,
// random backpressure, mid-stream reset and an exhaustive input sweep.
`timescale 1ns/1ps

module tb_k2_unscale;

  localparam int QM = 3329;
`ifdef K2U_SKID_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_data = 12'd0;
  logic        in_ready;
  logic        out_valid;
  logic        out_last;
  logic [11:0] out_data;

  int errors = 0;
  int checks = 0;

  logic        s_in_xfer;
  logic        s_out_xfer;
  logic        s_ov;
  logic        s_ol;
  logic [11:0] s_od;

  k2_unscale dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Reference: canonical (signed x) * 169^-1 mod Q.
  function automatic int ref_unscale(input logic [11:0] x);
    int a;
    a = int'($signed(x));
    a = ((a % QM) + QM) % QM;
    return (a * 2285) % QM;
  endfunction

  function automatic int canon(input logic [11:0] x);
    int a;
    a = int'($signed(x));
    return ((a % QM) + QM) % QM;
  endfunction

  // Drive one cycle at the falling edge and capture what will transfer.
  task automatic step(input logic v, input logic [11:0] d, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
    s_in_xfer  = in_valid & in_ready;
    s_out_xfer = out_valid & out_ready;
    s_ov = out_valid;
    s_od = out_data;
    s_ol = out_last;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 12'd0) begin errors++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_vectors();
    logic [11:0] vin [5];
    int          vexp [5];
    int          lat;
    bit          got;
    vin[0] = 12'd169;  vexp[0] = 1;
    vin[1] = 12'd0;    vexp[1] = 0;
    vin[2] = 12'hFFF;  vexp[2] = 1044;
    vin[3] = 12'hF57;  vexp[3] = 3328;
    vin[4] = 12'd2047; vexp[4] = 150;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vin[i], 1'b1);
      checks++; if (!s_in_xfer) begin errors++; $display("FAIL vec_accept[%0d] got=0 want=1", i); end
      lat = 0;
      got = 1'b0;
      for (int c = 1; c <= 10 && !got; c++) begin
        step(1'b0, 12'd0, 1'b1);
        if (s_ov) begin
          got = 1'b1;
          lat = c;
        end
      end
      checks++; if (!got || lat != LAT) begin errors++; $display("FAIL vec_latency[%0d] got=%0d want=%0d", i, lat, LAT); end
      checks++; if (int'(s_od) != vexp[i]) begin errors++; $display("FAIL vec_data[%0d] in=%h got=%0d want=%0d", i, vin[i], s_od, vexp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] q[$];
    logic [11:0] d;
    int nout, nin, prev;
    bit gap;
    apply_reset();
    nout = 0; nin = 0; prev = -1; gap = 1'b0;
    for (int c = 0; c < 256 + LAT + 6; c++) begin
      d = 12'($urandom);
      if (c < 256) step(1'b1, d, 1'b1);
      else step(1'b0, 12'd0, 1'b1);
      if (s_in_xfer) begin q.push_back(d); nin++; end
      if (s_out_xfer) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got=%0d want=none", s_od);
        end else begin
          d = q.pop_front();
          if (int'(s_od) != ref_unscale(d)) begin errors++; $display("FAIL b2b_data[%0d] got=%0d want=%0d", nout, s_od, ref_unscale(d)); end
        end
        checks++; if (s_ol !== (nout == 255)) begin errors++; $display("FAIL b2b_last[%0d] got=%b want=%b", nout, s_ol, (nout == 255)); end
        if (prev >= 0 && c != prev + 1) gap = 1'b1;
        prev = c;
        nout++;
      end
    end
    checks++; if (nin != 256) begin errors++; $display("FAIL b2b_accepted got=%0d want=256", nin); end
    checks++; if (nout != 256) begin errors++; $display("FAIL b2b_outputs got=%0d want=256", nout); end
    checks++; if (gap) begin errors++; $display("FAIL b2b_consecutive got=gap want=none"); end
  endtask

  task automatic test_random_stall();
    logic [11:0] q[$];
    logic [11:0] d, prev_od, e;
    logic v, rdy, prev_ol;
    bit prev_stall;
    int sent, nout;
    apply_reset();
    sent = 0; nout = 0; prev_stall = 1'b0; prev_od = 12'd0; prev_ol = 1'b0;
    for (int c = 0; c < 20000 && nout < 1000; c++) begin
      v   = (sent < 1000) && ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      d   = 12'($urandom);
      step(v, d, rdy);
      if (s_in_xfer) begin q.push_back(d); sent++; end
      if (prev_stall) begin
        checks++;
        if (!s_ov || s_od !== prev_od || s_ol !== prev_ol) begin
          errors++; $display("FAIL stall_hold valid=%b data=%0d last=%b want valid=1 data=%0d last=%b", s_ov, s_od, s_ol, prev_od, prev_ol);
        end
      end
      if (s_out_xfer) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected got=%0d want=none", s_od);
        end else begin
          e = q.pop_front();
          if (int'(s_od) != ref_unscale(e) || s_ol !== ((nout % 256) == 255)) begin
            errors++; $display("FAIL rnd_out[%0d] got=%0d/%b want=%0d/%b", nout, s_od, s_ol, ref_unscale(e), ((nout % 256) == 255));
          end
        end
        nout++;
      end
      prev_stall = s_ov & ~rdy;
      prev_od = s_od;
      prev_ol = s_ol;
    end
    checks++; if (nout != 1000) begin errors++; $display("FAIL rnd_count got=%0d want=1000", nout); end
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 12'd0, 1'b1);
      if (s_ov) nout++;
    end
    checks++; if (nout != 1000 || q.size() != 0) begin errors++; $display("FAIL rnd_extra got=%0d pending=%0d want=1000/0", nout, q.size()); end
  endtask

  task automatic test_reset_midstream();
    logic [11:0] q[$];
    logic [11:0] d, e;
    bit got;
    int nout;
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 12'($urandom), 1'b0);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step(1'b0, 12'd0, 1'b0);
      got = s_ov;
    end
    checks++; if (!got) begin errors++; $display("FAIL mid_inflight got=0 want=1"); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL mid_reset_last got=%b want=0", out_last); end
    @(negedge clk);
    rst = 1'b1;
    nout = 0;
    for (int c = 0; c < 256 + LAT + 6; c++) begin
      d = 12'($urandom);
      if (c < 256) step(1'b1, d, 1'b1);
      else step(1'b0, 12'd0, 1'b1);
      if (s_in_xfer) q.push_back(d);
      if (s_out_xfer) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL mid_unexpected got=%0d want=none", s_od);
        end else begin
          e = q.pop_front();
          if (int'(s_od) != ref_unscale(e) || s_ol !== (nout == 255)) begin
            errors++; $display("FAIL mid_out[%0d] got=%0d/%b want=%0d/%b", nout, s_od, s_ol, ref_unscale(e), (nout == 255));
          end
        end
        nout++;
      end
    end
    checks++; if (nout != 256) begin errors++; $display("FAIL mid_count got=%0d want=256", nout); end
  endtask

  task automatic test_sweep();
    logic [11:0] q[$];
    logic [11:0] x;
    int sent, nout;
    apply_reset();
    sent = 0; nout = 0;
    for (int c = 0; c < 4096 + 64 && nout < 4096; c++) begin
      step(sent < 4096, 12'(sent), 1'b1);
      if (s_in_xfer) begin q.push_back(12'(sent)); sent++; end
      if (s_out_xfer && q.size() != 0) begin
        x = q.pop_front();
        checks++;
        if (int'(s_od) >= QM || (169 * int'(s_od)) % QM != canon(x)) begin
          errors++; $display("FAIL sweep in=%h got=%0d want=%0d", x, s_od, ref_unscale(x));
        end
        nout++;
      end
    end
    checks++; if (nout != 4096) begin errors++; $display("FAIL sweep_count got=%0d want=4096", nout); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random_stall();
    test_reset_midstream();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
